alu_muldiv_control: RTL and testbench

// - Next-generation ALU controller for the SiMPLE core. Decodes alu_op_type/funct3/funct7 into the
//   5-bit ALU function code, and additionally decodes and sequences RV32M/RV64M mul/div/rem ops on
//   an internal iterative datapath with a start/busy/result handshake. Sits between the main

---
 rtl/alu_muldiv_control.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_muldiv_control.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_control.sv
// ALU function decoder plus an iterative RV32M/RV64M multiply/divide sequencer.
// Base ops decode combinationally; M ops run on a shift-add / restoring-divide datapath.
module alu_muldiv_control #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter bit ENABLE_M       = 1'b1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [1:0]      alu_op_type,
  input  logic [2:0]      inst_funct3,
  input  logic [6:0]      inst_funct7,
  input  logic            in_valid,
  input  logic            kill,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [4:0]      alu_function,
  output logic            md_op,
  output logic            busy,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] CTL_ALU_ADD    = 2'b00;
  localparam logic [1:0] CTL_ALU_OP     = 2'b01;
  localparam logic [1:0] CTL_ALU_OP_IMM = 2'b10;
  localparam logic [1:0] CTL_ALU_BRANCH = 2'b11;

  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SLL  = 5'd3;
  localparam logic [4:0] ALU_SLT  = 5'd4;
  localparam logic [4:0] ALU_SLTU = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_OR   = 5'd9;
  localparam logic [4:0] ALU_AND  = 5'd10;
  localparam logic [4:0] ALU_SEQ  = 5'd11;

  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, result_q, result_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d, rneg_q, rneg_d, valid_q, valid_d;

  assign md_op = ENABLE_M && (alu_op_type == CTL_ALU_OP) && (inst_funct7 == 7'b0000001);

  always_comb begin
    alu_function = 5'd0;
    case (alu_op_type)
      CTL_ALU_ADD: alu_function = ALU_ADD;
      CTL_ALU_OP, CTL_ALU_OP_IMM: begin
        case (inst_funct3)
          3'd0: alu_function = (alu_op_type == CTL_ALU_OP && inst_funct7[5]) ? ALU_SUB : ALU_ADD;
          3'd1: alu_function = ALU_SLL;
          3'd2: alu_function = ALU_SLT;
          3'd3: alu_function = ALU_SLTU;
          3'd4: alu_function = ALU_XOR;
          3'd5: alu_function = inst_funct7[5] ? ALU_SRA : ALU_SRL;
          3'd6: alu_function = ALU_OR;
          default: alu_function = ALU_AND;
        endcase
        // funct7[5] only has meaning for register SUB/SRA; elsewhere the combo is undefined
        if (alu_op_type == CTL_ALU_OP && inst_funct7[5] && inst_funct3 != 3'd0 && inst_funct3 != 3'd5)
          alu_function = 5'd0;
        if (alu_op_type == CTL_ALU_OP_IMM && inst_funct7[5] && inst_funct3[1:0] == 2'b01)
          alu_function = ALU_SRA;
      end
      default: begin
        case (inst_funct3[2:1])
          2'b00:   alu_function = ALU_SEQ;
          2'b10:   alu_function = ALU_SLT;
          2'b11:   alu_function = ALU_SLTU;
          default: alu_function = 5'd0;
        endcase
      end
    endcase
    if (md_op) alu_function = ALU_ADD;
  end

  logic            sign_a, sign_b, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_val;

  assign sign_a      = (inst_funct3 == 3'd1) | (inst_funct3 == 3'd2) | (inst_funct3 == 3'd4) | (inst_funct3 == 3'd6);
  assign sign_b      = (inst_funct3 == 3'd1) | (inst_funct3 == 3'd4) | (inst_funct3 == 3'd6);
  assign a_neg       = sign_a & operand_a[XLEN-1];
  assign b_neg       = sign_b & operand_b[XLEN-1];
  assign a_mag       = a_neg ? -operand_a : operand_a;
  assign b_mag       = b_neg ? -operand_b : operand_b;
  assign div_zero    = inst_funct3[2] & (operand_b == '0);
  assign div_ovf     = inst_funct3[2] & ~inst_funct3[0] & (operand_a == MIN_NEG) & (operand_b == '1);
  assign special_val = div_zero ? (inst_funct3[1] ? operand_a : '1) : (inst_funct3[1] ? '0 : operand_a);

  // One RUN cycle: BITS_PER_CYCLE iterations on {hi,lo}; mul shifts right, div shifts left.
  logic [XLEN-1:0] hi_n, lo_n;
  logic [XLEN:0]   sum, shifted, diff;
  always_comb begin
    hi_n    = hi_q;
    lo_n    = lo_q;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (!op_q[2]) begin
        sum  = {1'b0, hi_n} + (lo_n[0] ? {1'b0, b_q} : '0);
        hi_n = sum[XLEN:1];
        lo_n = {sum[0], lo_n[XLEN-1:1]};
      end else begin
        shifted = {hi_n, lo_n[XLEN-1]};
        lo_n    = {lo_n[XLEN-2:0], 1'b0};
        if (shifted >= {1'b0, b_q}) begin
          diff    = shifted - {1'b0, b_q};
          hi_n    = diff[XLEN-1:0];
          lo_n[0] = 1'b1;
        end else begin
          hi_n = shifted[XLEN-1:0];
        end
      end
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;
  assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = rneg_q ? -hi_q : hi_q;
  assign fix_val  = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                            : ((op_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && md_op && !kill) begin
          op_d    = inst_funct3;
          b_d     = b_mag;
          lo_d    = a_mag;
          hi_d    = '0;
          count_d = CW'(STEPS);
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          if (div_zero || div_ovf) begin
            result_d = special_val;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        hi_d    = hi_n;
        lo_d    = lo_n;
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_val;
        valid_d  = 1'b1;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // A flush wins over everything, including the pulse about to be raised
    if (kill) begin
      state_d  = S_IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result_valid = valid_q;
  assign result       = result_q;
  assign stall        = (md_op & in_valid & (state_q == S_IDLE)) | (busy & ~valid_q);

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Directed bench for alu_muldiv_control: decode table, M-op results and latency for
// BITS_PER_CYCLE 1 and 4 instances sharing stimulus, special cases, kill and async reset.
module tb_alu_muldiv_control;

  localparam logic [1:0] CTL_ADD = 2'b00, CTL_OP = 2'b01, CTL_IMM = 2'b10, CTL_BR = 2'b11;
  localparam logic [4:0] F_ADD = 5'd1, F_SUB = 5'd2, F_SLT = 5'd4, F_SLTU = 5'd5, F_XOR = 5'd6,
                         F_SRL = 5'd7, F_SRA = 5'd8, F_SEQ = 5'd11;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  alu_op_type = 2'b00;
  logic [2:0]  inst_funct3 = 3'd0;
  logic [6:0]  inst_funct7 = 7'd0;
  logic        in_valid = 1'b0;
  logic        kill = 1'b0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;

  logic [4:0]  fn1, fn4;
  logic        md1, md4, busy1, busy4, stall1, stall4, rv1, rv4;
  logic [31:0] res1, res4;

  int checks = 0;
  int errors = 0;

  alu_muldiv_control #(.XLEN(32), .BITS_PER_CYCLE(1), .ENABLE_M(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .alu_op_type(alu_op_type), .inst_funct3(inst_funct3),
    .inst_funct7(inst_funct7), .in_valid(in_valid), .kill(kill), .operand_a(operand_a),
    .operand_b(operand_b), .alu_function(fn1), .md_op(md1), .busy(busy1), .stall(stall1),
    .result_valid(rv1), .result(res1));

  alu_muldiv_control #(.XLEN(32), .BITS_PER_CYCLE(4), .ENABLE_M(1'b1)) dut4 (
    .clock(clock), .reset_n(reset_n), .alu_op_type(alu_op_type), .inst_funct3(inst_funct3),
    .inst_funct7(inst_funct7), .in_valid(in_valid), .kill(kill), .operand_a(operand_a),
    .operand_b(operand_b), .alu_function(fn4), .md_op(md4), .busy(busy4), .stall(stall4),
    .result_valid(rv4), .result(res4));

  always #5 clock = ~clock;

  // Presents one M op for a single cycle; reports, per instance, the edge count (accept edge = 1)
  // at which result_valid was first seen and the result then. -1 means it never came.
  task automatic issue_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output int lat1, output logic [31:0] r1,
                           output int lat4, output logic [31:0] r4);
    @(negedge clock);
    alu_op_type = CTL_OP; inst_funct3 = f3; inst_funct7 = 7'b0000001;
    operand_a = a; operand_b = b; in_valid = 1'b1;
    lat1 = -1; lat4 = -1; r1 = 32'hx; r4 = 32'hx;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      in_valid = 1'b0;
      if (rv1 && lat1 < 0) begin lat1 = k; r1 = res1; end
      if (rv4 && lat4 < 0) begin lat4 = k; r4 = res4; end
      if (lat1 >= 0 && lat4 >= 0) break;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (busy1 !== 1'b0 || rv1 !== 1'b0 || res1 !== 32'd0 || stall1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rv=%b result=%h stall=%b, required 0 0 00000000 0", busy1, rv1, res1, stall1);
    end
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_decode;
    logic [1:0] t_op [10] = '{CTL_OP, CTL_IMM, CTL_IMM, CTL_BR, CTL_BR,   CTL_BR, CTL_BR, CTL_OP, CTL_ADD, CTL_OP};
    logic [2:0] t_f3 [10] = '{3'd0,   3'd0,    3'd5,    3'd7,   3'd0,     3'd4,   3'd2,   3'd4,   3'd3,    3'd5};
    logic [6:0] t_f7 [10] = '{7'h20,  7'h20,   7'h20,   7'h00,  7'h00,    7'h00,  7'h00,  7'h00,  7'h00,   7'h00};
    logic [4:0] t_ex [10] = '{F_SUB,  F_ADD,   F_SRA,   F_SLTU, F_SEQ,    F_SLT,  5'd0,   F_XOR,  F_ADD,   F_SRL};
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      alu_op_type = t_op[i]; inst_funct3 = t_f3[i]; inst_funct7 = t_f7[i];
      #1;
      checks++;
      if (fn1 !== t_ex[i] || md1 !== 1'b0) begin
        errors++;
        $display("FAIL decode_%0d: alu_function=%0d md_op=%b, required %0d 0", i, fn1, md1, t_ex[i]);
      end
    end
    alu_op_type = CTL_OP; inst_funct3 = 3'd4; inst_funct7 = 7'b0000001; #1;
    checks++;
    if (fn1 !== F_ADD || md1 !== 1'b1) begin
      errors++;
      $display("FAIL decode_mdop: alu_function=%0d md_op=%b, required %0d 1", fn1, md1, F_ADD);
    end
  endtask

  task automatic test_arith;
    logic [2:0]  v_f3 [13] = '{3'd0, 3'd3, 3'd2, 3'd1, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd0};
    logic [31:0] v_a  [13] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9,
                               32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'hFFFFFFFF, 32'h00012345};
    logic [31:0] v_b  [13] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd5, 32'h80000000, 32'd2,
                               32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd1, 32'h00001000};
    logic [31:0] v_ex [13] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF, 32'h12345000};
    int l1, l4;
    logic [31:0] r1, r4;
    for (int i = 0; i < 13; i++) begin
      issue_mop(v_f3[i], v_a[i], v_b[i], l1, r1, l4, r4);
      checks++;
      if (r1 !== v_ex[i] || l1 != 34) begin
        errors++;
        $display("FAIL arith_bpc1_%0d: result=%h latency=%0d, required %h 34", i, r1, l1, v_ex[i]);
      end
      checks++;
      if (r4 !== v_ex[i] || l4 != 10) begin
        errors++;
        $display("FAIL arith_bpc4_%0d: result=%h latency=%0d, required %h 10", i, r4, l4, v_ex[i]);
      end
    end
  endtask

  task automatic test_special;
    logic [2:0]  v_f3 [5] = '{3'd5, 3'd7, 3'd6, 3'd4, 3'd4};
    logic [31:0] v_a  [5] = '{32'd7, 32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFF9};
    logic [31:0] v_b  [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [31:0] v_ex [5] = '{32'hFFFFFFFF, 32'd7, 32'd0, 32'h80000000, 32'hFFFFFFFF};
    int l1, l4;
    logic [31:0] r1, r4;
    for (int i = 0; i < 5; i++) begin
      issue_mop(v_f3[i], v_a[i], v_b[i], l1, r1, l4, r4);
      checks++;
      if (r1 !== v_ex[i] || l1 != 1 || r4 !== v_ex[i] || l4 != 1) begin
        errors++;
        $display("FAIL special_%0d: result=%h/%h latency=%0d/%0d, required %h latency 1", i, r1, r4, l1, l4, v_ex[i]);
      end
    end
  endtask

  task automatic test_kill;
    int l1, l4, pulses;
    logic [31:0] r1, r4;
    issue_mop(3'd0, 32'd3, 32'd4, l1, r1, l4, r4);
    checks++;
    if (r1 !== 32'd12 || r4 !== 32'd12) begin
      errors++;
      $display("FAIL kill_pre: result=%h/%h, required 0000000c", r1, r4);
    end
    @(negedge clock);
    alu_op_type = CTL_OP; inst_funct3 = 3'd0; inst_funct7 = 7'b0000001;
    operand_a = 32'd5; operand_b = 32'd6; in_valid = 1'b1;
    #1;
    checks++;
    if (stall1 !== 1'b1) begin
      errors++;
      $display("FAIL stall_accept: stall=%b, required 1", stall1);
    end
    @(posedge clock); #1 in_valid = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    checks++;
    if (busy1 !== 1'b1 || stall1 !== 1'b1 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL busy_run: busy=%b stall=%b busy4=%b, required 1 1 1", busy1, stall1, busy4);
    end
    kill = 1'b1;
    @(posedge clock); #1 kill = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || busy4 !== 1'b0 || rv1 !== 1'b0 || rv4 !== 1'b0) begin
      errors++;
      $display("FAIL kill_idle: busy=%b/%b rv=%b/%b, required all 0", busy1, busy4, rv1, rv4);
    end
    pulses = 0;
    repeat (40) begin @(posedge clock); #1 if (rv1 || rv4) pulses++; end
    checks++;
    if (pulses != 0 || res1 !== 32'd12 || res4 !== 32'd12) begin
      errors++;
      $display("FAIL kill_quiet: pulses=%0d result=%h/%h, required 0 0000000c", pulses, res1, res4);
    end
    // kill coincident with acceptance cancels the start
    @(negedge clock); in_valid = 1'b1; kill = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0; kill = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL kill_accept: busy=%b/%b, required 0 0", busy1, busy4);
    end
    issue_mop(3'd0, 32'd5, 32'd6, l1, r1, l4, r4);
    checks++;
    if (r1 !== 32'd30 || l1 != 34 || r4 !== 32'd30 || l4 != 10) begin
      errors++;
      $display("FAIL kill_after: result=%h/%h latency=%0d/%0d, required 0000001e 34/10", r1, r4, l1, l4);
    end
  endtask

  task automatic test_reset_mid;
    int pulses, busy_seen;
    @(negedge clock);
    alu_op_type = CTL_OP; inst_funct3 = 3'd4; inst_funct7 = 7'b0000001;
    operand_a = 32'd1000; operand_b = 32'd9; in_valid = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock); #1 reset_n = 1'b0;
    #1;
    checks++;
    if (busy1 !== 1'b0 || rv1 !== 1'b0 || res1 !== 32'd0 || busy4 !== 1'b0 || res4 !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: busy=%b/%b rv=%b result=%h/%h, required 0 0 0 0", busy1, busy4, rv1, res1, res4);
    end
    @(negedge clock); reset_n = 1'b1;
    pulses = 0; busy_seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (rv1 || rv4) pulses++;
      if (busy1 || busy4) busy_seen++;
    end
    checks++;
    if (pulses != 0 || busy_seen != 0) begin
      errors++;
      $display("FAIL reset_release: pulses=%0d busy_cycles=%0d, required 0 0", pulses, busy_seen);
    end
  endtask

  task automatic test_back_to_back;
    int l1, l4;
    logic [31:0] r1, r4;
    issue_mop(3'd3, 32'h80000000, 32'h00000004, l1, r1, l4, r4);
    checks++;
    if (r1 !== 32'd2 || r4 !== 32'd2) begin
      errors++;
      $display("FAIL b2b_first: result=%h/%h, required 00000002", r1, r4);
    end
    issue_mop(3'd7, 32'd13, 32'd5, l1, r1, l4, r4);
    checks++;
    if (r1 !== 32'd3 || l1 != 34 || r4 !== 32'd3 || l4 != 10) begin
      errors++;
      $display("FAIL b2b_second: result=%h/%h latency=%0d/%0d, required 00000003 34/10", r1, r4, l1, l4);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_arith();
    test_special();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
